// File: rtl/board_line_scanner.sv
// Replays a snapshot of the Connect-4 board into the four-in-a-row recognizer, line by line,
// with a 00 separator after every line, and latches the first winner the recognizer reports.
module board_line_scanner #(
   parameter int COLS = 7,
   parameter int ROWS = 6
) (
   input  logic                     next,
   input  logic                     reset,
   input  logic                     go,
   input  logic [2*ROWS*COLS-1:0]   board,
   input  logic [1:0]               win_in,
   output logic [1:0]               piece,
   output logic                     busy,
   output logic                     done,
   output logic [1:0]               winner
);

   // state   | meaning
   // IDLE    | waiting for go after reset
   // PRIME   | one 00 cycle to flush the recognizer
   // ROW     | streaming rows, left to right, top to bottom
   // COL     | streaming columns, top to bottom
   // DIAG    | streaming down-right diagonals of length >= 4
   // ANTI    | streaming down-left anti-diagonals of length >= 4
   // DONE    | scan finished or aborted on a win; winner is valid

   localparam int NCELL = ROWS * COLS;
   localparam int MAXD  = (ROWS > COLS) ? ROWS : COLS;
   localparam int IW    = $clog2(MAXD);
   localparam int NDIAG = ROWS + COLS - 7;
   localparam int LW    = (NDIAG > 1) ? $clog2(NDIAG) : 1;
   localparam int XW    = $clog2(NCELL);

   localparam logic [IW-1:0] R_LAST  = IW'(ROWS - 1);
   localparam logic [IW-1:0] C_LAST  = IW'(COLS - 1);
   localparam logic [IW-1:0] C_ANTI0 = IW'(3);
   localparam logic [LW-1:0] L_LAST  = LW'(NDIAG - 1);
   localparam logic [LW-1:0] L_TOP   = LW'(COLS - 4);

   typedef enum logic [2:0] {
      S_IDLE, S_PRIME, S_ROW, S_COL, S_DIAG, S_ANTI, S_DONE
   } state_t;

   state_t          r_state;
   logic [IW-1:0]   r_row;
   logic [IW-1:0]   r_col;
   logic            r_sep;
   logic [LW-1:0]   r_line;
   logic [1:0]      r_piece;
   logic [1:0]      r_winner;
   logic [1:0]      r_snap [NCELL];

   state_t          w_state_nxt;
   logic [IW-1:0]   w_row_nxt;
   logic [IW-1:0]   w_col_nxt;
   logic            w_sep_nxt;
   logic [LW-1:0]   w_line_nxt;
   logic [LW-1:0]   w_line_inc;
   logic [IW-1:0]   w_diag_row;
   logic [IW-1:0]   w_diag_col;
   logic [IW-1:0]   w_anti_row;
   logic [IW-1:0]   w_anti_col;
   logic            w_scan;
   logic            w_win;
   logic            w_accept;
   logic [XW-1:0]   w_idx;
   logic [1:0]      w_cell;
   logic [1:0]      w_piece_nxt;

   assign w_scan     = r_state inside {S_ROW, S_COL, S_DIAG, S_ANTI};
   assign w_win      = w_scan && (win_in != 2'b00);
   assign w_accept   = (r_state == S_IDLE || r_state == S_DONE) && go;
   assign w_line_inc = r_line + 1'b1;

   // Start cell of the following diagonal: along the top row first, then down the edge column.
   assign w_diag_row = (w_line_inc <= L_TOP) ? '0               : IW'(w_line_inc - L_TOP);
   assign w_diag_col = (w_line_inc <= L_TOP) ? IW'(w_line_inc)  : '0;
   assign w_anti_row = (w_line_inc <= L_TOP) ? '0               : IW'(w_line_inc - L_TOP);
   assign w_anti_col = (w_line_inc <= L_TOP) ? IW'(w_line_inc) + C_ANTI0 : C_LAST;

   always_ff @(posedge next) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_row    <= '0;
         r_col    <= '0;
         r_sep    <= 1'b0;
         r_line   <= '0;
         r_piece  <= 2'b00;
         r_winner <= 2'b00;
      end else begin
         r_state  <= w_state_nxt;
         r_row    <= w_row_nxt;
         r_col    <= w_col_nxt;
         r_sep    <= w_sep_nxt;
         r_line   <= w_line_nxt;
         r_piece  <= w_piece_nxt;
         if (w_win)
            r_winner <= win_in;
         else if (w_accept)
            r_winner <= 2'b00;
      end
   end

   always_ff @(posedge next) begin
      if (reset && w_accept) begin
         for (int k = 0; k < NCELL; k++)
            r_snap[k] <= board[k*2 +: 2];
      end
   end

   // Counters always describe the item that piece will hold after the edge.
   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_col_nxt   = r_col;
      w_sep_nxt   = r_sep;
      w_line_nxt  = r_line;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (go) w_state_nxt = S_PRIME;
         end
         S_PRIME: begin
            w_state_nxt = S_ROW;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
            w_sep_nxt   = 1'b0;
         end
         S_ROW: begin
            if (r_sep) begin
               w_sep_nxt = 1'b0;
               w_col_nxt = '0;
               if (r_row == R_LAST) begin
                  w_state_nxt = S_COL;
                  w_row_nxt   = '0;
               end else begin
                  w_row_nxt = r_row + 1'b1;
               end
            end else if (r_col == C_LAST) begin
               w_sep_nxt = 1'b1;
            end else begin
               w_col_nxt = r_col + 1'b1;
            end
         end
         S_COL: begin
            if (r_sep) begin
               w_sep_nxt = 1'b0;
               w_row_nxt = '0;
               if (r_col == C_LAST) begin
                  w_state_nxt = S_DIAG;
                  w_col_nxt   = '0;
                  w_line_nxt  = '0;
               end else begin
                  w_col_nxt = r_col + 1'b1;
               end
            end else if (r_row == R_LAST) begin
               w_sep_nxt = 1'b1;
            end else begin
               w_row_nxt = r_row + 1'b1;
            end
         end
         S_DIAG: begin
            if (r_sep) begin
               w_sep_nxt = 1'b0;
               if (r_line == L_LAST) begin
                  w_state_nxt = S_ANTI;
                  w_row_nxt   = '0;
                  w_col_nxt   = C_ANTI0;
                  w_line_nxt  = '0;
               end else begin
                  w_line_nxt = w_line_inc;
                  w_row_nxt  = w_diag_row;
                  w_col_nxt  = w_diag_col;
               end
            end else if (r_row == R_LAST || r_col == C_LAST) begin
               w_sep_nxt = 1'b1;
            end else begin
               w_row_nxt = r_row + 1'b1;
               w_col_nxt = r_col + 1'b1;
            end
         end
         S_ANTI: begin
            if (r_sep) begin
               w_sep_nxt = 1'b0;
               if (r_line == L_LAST) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_line_nxt = w_line_inc;
                  w_row_nxt  = w_anti_row;
                  w_col_nxt  = w_anti_col;
               end
            end else if (r_row == R_LAST || r_col == '0) begin
               w_sep_nxt = 1'b1;
            end else begin
               w_row_nxt = r_row + 1'b1;
               w_col_nxt = r_col - 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_win) w_state_nxt = S_DONE;
   end

   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      w_piece_nxt = 2'b00;
      w_idx       = XW'(w_row_nxt) * XW'(COLS) + XW'(w_col_nxt);
      w_cell      = r_snap[w_idx];
      case (r_state)
         S_PRIME, S_ROW, S_COL, S_DIAG, S_ANTI: busy = 1'b1;
         S_DONE:                                done = 1'b1;
         default: ;
      endcase
      // Cell code 11 is not a legal piece; present it as empty.
      if ((w_state_nxt inside {S_ROW, S_COL, S_DIAG, S_ANTI}) && !w_sep_nxt)
         w_piece_nxt = (w_cell == 2'b11) ? 2'b00 : w_cell;
   end

   assign piece  = r_piece;
   assign winner = r_winner;

endmodule

// File: tb/tb_board_line_scanner.sv
// Bench for board_line_scanner: a line-list reference model predicts the piece stream and the
// first winner, and a small run-counting recognizer closes the loop on win_in.
module tb_board_line_scanner;
   localparam int ROWS  = 6;
   localparam int COLS  = 7;
   localparam int NCELL = ROWS * COLS;
   localparam int BW    = 2 * NCELL;

   logic          next   = 1'b0;
   logic          reset  = 1'b0;
   logic          go     = 1'b0;
   logic [BW-1:0] board  = '0;
   logic [1:0]    win_in;
   logic [1:0]    piece;
   logic          busy;
   logic          done;
   logic [1:0]    winner;

   logic          tie_win = 1'b1;
   logic [1:0]    rec_col = 2'b00;
   logic [1:0]    rec_out = 2'b00;
   int            rec_cnt = 0;

   int total = 0;
   int bad   = 0;
   int items[$];

   assign win_in = tie_win ? 2'b00 : rec_out;

   board_line_scanner #(.COLS(COLS), .ROWS(ROWS)) dut (
      .next   (next),
      .reset  (reset),
      .go     (go),
      .board  (board),
      .win_in (win_in),
      .piece  (piece),
      .busy   (busy),
      .done   (done),
      .winner (winner)
   );

   always #5 next = ~next;

   // Recognizer stand-in: one registered stage, out flags a run of four equal non-empty pieces.
   always @(posedge next) begin
      if (!reset || piece == 2'b00) begin
         rec_cnt <= 0;
         rec_col <= 2'b00;
         rec_out <= 2'b00;
      end else if (piece == rec_col) begin
         rec_cnt <= rec_cnt + 1;
         rec_out <= (rec_cnt + 1 >= 4) ? piece : 2'b00;
      end else begin
         rec_col <= piece;
         rec_cnt <= 1;
         rec_out <= 2'b00;
      end
   end

   task automatic step();
      @(posedge next);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_line(input int r0, input int c0, input int dc);
      int r;
      int c;
      r = r0;
      c = c0;
      while (r < ROWS && c >= 0 && c < COLS) begin
         items.push_back(r * COLS + c);
         r++;
         c += dc;
      end
      items.push_back(-1);
   endtask

   // Scan order as a flat list of cell indices; -1 marks a separator.
   task automatic build_items();
      items.delete();
      for (int r = 0; r < ROWS; r++) push_line(r, 0, 0) ;
      items.delete();
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) items.push_back(r * COLS + c);
         items.push_back(-1);
      end
      for (int c = 0; c < COLS; c++) begin
         for (int r = 0; r < ROWS; r++) items.push_back(r * COLS + c);
         items.push_back(-1);
      end
      for (int c = 0; c <= COLS - 4; c++) push_line(0, c, 1);
      for (int r = 1; r <= ROWS - 4; r++) push_line(r, 0, 1);
      for (int c = 3; c < COLS; c++)      push_line(0, c, -1);
      for (int r = 1; r <= ROWS - 4; r++) push_line(r, COLS - 1, -1);
   endtask

   function automatic logic [1:0] emit(input logic [BW-1:0] b, input int i);
      logic [1:0] v;
      if (items[i] < 0) return 2'b00;
      v = b[items[i]*2 +: 2];
      return (v == 2'b11) ? 2'b00 : v;
   endfunction

   // Item i is loaded at edge i+1, seen by the recognizer at i+2, sampled by the scanner at i+3.
   task automatic predict(input logic [BW-1:0] b, input bit use_rec,
                          output int dedge, output logic [1:0] w);
      int run;
      bit found;
      logic [1:0] col;
      logic [1:0] v;
      dedge = items.size() + 1;
      w     = 2'b00;
      run   = 0;
      col   = 2'b00;
      found = 1'b0;
      if (use_rec) begin
         for (int i = 0; i < items.size(); i++) begin
            if (!found) begin
               v = emit(b, i);
               if (v == 2'b00)      run = 0;
               else if (v == col)   run++;
               else                 run = 1;
               col = v;
               if (run == 4) begin
                  found = 1'b1;
                  dedge = i + 3;
                  w     = v;
               end
            end
         end
      end
   endtask

   task automatic run_scan(input logic [BW-1:0] b, input bit use_rec, input bit pulse_go,
                           input string tag);
      int dedge;
      logic [1:0] w;
      tie_win = !use_rec;
      predict(b, use_rec, dedge, w);
      board = b;
      go    = 1'b1;
      step();
      go    = 1'b0;
      check({tag, " prime"}, {2'b00, busy, done, piece, winner}, {2'b00, 2'b10, 2'b00, 2'b00});
      for (int e = 1; e <= dedge; e++) begin
         board = BW'({$urandom, $urandom, $urandom});
         go    = pulse_go && (e == 10 || e == 100);
         step();
         if (e < dedge)
            check($sformatf("%s e%0d", tag, e), {4'b0000, busy, done, piece},
                  {4'b0000, 2'b10, emit(b, e - 1)});
         else
            check($sformatf("%s done e%0d", tag, e), {2'b00, busy, done, piece, winner},
                  {2'b00, 2'b01, 2'b00, w});
      end
      go = 1'b0;
      step();
      check({tag, " hold"}, {2'b00, busy, done, piece, winner}, {2'b00, 2'b01, 2'b00, w});
   endtask

   function automatic logic [BW-1:0] rand_board(input int thr);
      logic [BW-1:0] b;
      b = '0;
      for (int k = 0; k < NCELL; k++)
         if ($urandom_range(99) < thr) b[k*2 +: 2] = 2'($urandom_range(3, 1));
      return b;
   endfunction

   initial begin
      logic [BW-1:0] b;
      build_items();

      reset = 1'b0;
      step();
      step();
      check("reset", {2'b00, busy, done, piece, winner}, 8'h00);
      reset = 1'b1;
      step();
      check("idle", {2'b00, busy, done, piece, winner}, 8'h00);

      run_scan('0, 1'b1, 1'b0, "empty");

      b = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            b[(r*COLS + c)*2 +: 2] = ((r + c) % 2 == 0) ? 2'b01 : 2'b10;
      run_scan(b, 1'b0, 1'b0, "order");

      // Red four on the bottom row: aborts inside ROW, before any column is streamed.
      b = '0;
      for (int c = 0; c < 4; c++) b[(5*COLS + c)*2 +: 2] = 2'b01;
      run_scan(b, 1'b1, 1'b0, "redrow");

      b = '0;
      for (int k = 0; k < 4; k++) b[(k*COLS + (6 - k))*2 +: 2] = 2'b10;
      for (int k = 0; k < 3; k++) b[(k*COLS + k)*2 +: 2] = 2'b01;
      run_scan(b, 1'b1, 1'b0, "anti");

      tie_win = 1'b1;
      b = rand_board(30);
      board = b;
      go = 1'b1;
      step();
      go = 1'b0;
      for (int e = 1; e < 60; e++) step();
      reset = 1'b0;
      step();
      check("midreset", {2'b00, busy, done, piece, winner}, 8'h00);
      reset = 1'b1;
      step();
      check("postreset", {2'b00, busy, done, piece, winner}, 8'h00);
      run_scan(b, 1'b1, 1'b0, "rescan");

      run_scan('0, 1'b1, 1'b1, "gopulse");

      for (int n = 0; n < 6; n++)
         run_scan(rand_board(8 + n * 7), 1'b1, 1'b0, $sformatf("rand%0d", n));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
